// File: rtl/calculator_n_if.sv
// Switch/button inputs and result/display outputs of calculator_n, bundled as one port.
// master drives operands and the button; slave is the calculator itself.
interface calculator_n_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             calc_button;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             done;
  logic [6:0]       seg;
  logic [7:0]       an;

  modport master (
    output a, b, op, calc_button,
    input  result, carry, overflow, done, seg, an
  );

  modport slave (
    input  a, b, op, calc_button,
    output result, carry, overflow, done, seg, an
  );
endinterface

// File: rtl/calculator_n.sv
// Button-triggered WIDTH-bit add/sub/AND/OR calculator with a debounced press input
// and a multiplexed active-low hex 7-segment readout of the held result.
module calculator_n #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  calculator_n_if.slave bus
);
  localparam int DIGITS = (WIDTH + 3) / 4;
  localparam int CNTW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SCW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic            s1_q, s2_q;
  logic            db_q, db_d, db_prev_q;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            press;

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q;
  logic [WIDTH:0]   sum_w, diff_w;

  logic [SCW-1:0] scan_q, scan_d;
  logic [2:0]     digit_q, digit_d;
  logic [7:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           scan_wrap;
  logic [31:0]    res_ext;
  logic [3:0]     nib;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Counter only advances while the synchronised level disagrees with db.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == CNTW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  always_comb begin
    sum_w    = {1'b0, bus.a} + {1'b0, bus.b};
    diff_w   = {1'b0, bus.a} - {1'b0, bus.b};
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    if (press) begin
      case (bus.op)
        OP_ADD: begin
          result_d = sum_w[WIDTH-1:0];
          carry_d  = sum_w[WIDTH];
          ovf_d    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
        end
        OP_SUB: begin
          result_d = diff_w[WIDTH-1:0];
          carry_d  = diff_w[WIDTH];
          ovf_d    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_w[WIDTH-1] != bus.a[WIDTH-1]);
        end
        OP_AND: begin
          result_d = bus.a & bus.b;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
        end
        default: begin
          result_d = bus.a | bus.b;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
        end
      endcase
    end
  end

  // seg/an are loaded with the upcoming digit on wrap, so they stay registered outputs.
  always_comb begin
    scan_wrap = (scan_q == SCW'(SCAN_DIV - 1));
    scan_d    = scan_wrap ? '0 : scan_q + SCW'(1);
    digit_d   = digit_q;
    an_d      = an_q;
    seg_d     = seg_q;
    res_ext   = 32'(result_q);
    nib       = '0;
    if (scan_wrap) begin
      digit_d = (digit_q == 3'(DIGITS - 1)) ? '0 : digit_q + 3'd1;
      nib     = 4'(res_ext >> {digit_d, 2'b00});
      an_d    = ~(8'b1 << digit_d);
      seg_d   = glyph(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      scan_q    <= '0;
      digit_q   <= '0;
      an_q      <= 8'hFE;
      seg_q     <= 7'b1000000;
    end else begin
      s1_q      <= bus.calc_button;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      done_q    <= press;
      scan_q    <= scan_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.done     = done_q;
  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
endmodule
